// File: rtl/window_feeder_pkg.sv
// window_feeder_pkg
//   Shared window geometry and pixel packing for the window feeder and the
//   Gaussian 4-block stage that consumes its windows. Both sides import this
//   package so the flat window packing stays bit-identical.
//   Packing: pixel (r,c), k = 14r + c, occupies bits
//   [(70-k)*bw-1 -: bw], i.e. row 0 col 0 sits in the MSBs.
package window_feeder_pkg;

  localparam int WIN_ROWS = 5;
  localparam int WIN_COLS = 14;
  localparam int STRIDE   = 12;
  localparam int OVERLAP  = 2;
  localparam int WIN_PIX  = WIN_ROWS * WIN_COLS;

  // LSB bit offset of pixel (r,c) inside a flat window of bw-bit pixels.
  function automatic int pix_lsb(input int r, input int c, input int bw);
    return (WIN_PIX - (WIN_COLS * r + c) - 1) * bw;
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// window_shift_reg
//   Column shift register feeding the window assembler. It retains the 13
//   most recent columns; together with the column being presented this
//   cycle they form the full 14-column window, exposed flat in the shared
//   packing. Because the window is always captured on the edge that accepts
//   its final column, the 14th column never needs its own storage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears retained columns)
//   en         : shift col_in in (one accepted column)
//   col_in     : incoming column, row 0 in the MS pixel
//   win_flat   : retained columns 0..12 plus col_in as column 13
import window_feeder_pkg::*;

module window_shift_reg #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [WIN_ROWS*BIT_WIDTH-1:0] col_in,
  output logic [WIN_PIX*BIT_WIDTH-1:0]  win_flat
);

  localparam int COL_W = WIN_ROWS * BIT_WIDTH;
  localparam int KEEP  = WIN_COLS - 1;

  logic [COL_W-1:0] col_q [KEEP];
  logic [COL_W-1:0] col_d [KEEP];

  // Oldest column at index 0, newest at KEEP-1.
  always_comb begin
    for (int i = 0; i < KEEP; i++) begin
      col_d[i] = col_q[i];
    end
    if (en) begin
      for (int i = 0; i < KEEP - 1; i++) begin
        col_d[i] = col_q[i + 1];
      end
      col_d[KEEP-1] = col_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEEP; i++) begin
        col_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < KEEP; i++) begin
        col_q[i] <= col_d[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIN_COLS; gi++) begin : g_col
      logic [COL_W-1:0] col_w;
      if (gi < KEEP) begin : g_ret
        assign col_w = col_q[gi];
      end else begin : g_new
        assign col_w = col_in;
      end
      for (genvar gr = 0; gr < WIN_ROWS; gr++) begin : g_row
        localparam int LSB = pix_lsb(gr, gi, BIT_WIDTH);
        assign win_flat[LSB +: BIT_WIDTH] = col_w[(WIN_ROWS-1-gr)*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  endgenerate

endmodule

// File: rtl/window_feeder.sv
// window_feeder
//   Builds 5x14 pixel windows from a column stream for the Gaussian 4-block
//   stage. Windows in a band start every 12 columns (2-column overlap); the
//   first window of a band needs 14 columns.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   col_in/col_valid/col_ready : column stream in (row 0 in the MS pixel)
//   win_out/win_valid/win_ready : registered 70-pixel window out
//   win_last              : window is the last one of the band
import window_feeder_pkg::*;

module window_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 98
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIN_ROWS*BIT_WIDTH-1:0] col_in,
  input  logic                          col_valid,
  output logic                          col_ready,
  output logic [WIN_PIX*BIT_WIDTH-1:0]  win_out,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic                          win_last
);

  localparam int CNT_W  = $clog2(WIN_COLS + 1);
  localparam int BCOL_W = $clog2(IMG_W);
  localparam int WIN_W  = WIN_PIX * BIT_WIDTH;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCOL_W-1:0] bcol_q, bcol_d;
  logic [WIN_W-1:0]  win_out_q, win_out_d;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;

  logic [CNT_W-1:0]  target_m1;
  logic              col_fire;
  logic              win_fire;
  logic              completes;
  logic              band_end;
  logic [WIN_W-1:0]  win_next;

  window_shift_reg #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (col_fire),
    .col_in   (col_in),
    .win_flat (win_next)
  );

  always_comb begin
    // Windows of a band end at bcol 13, 25, 37, ... so the first window
    // (bcol still below 14) needs a full 14 columns, later ones a stride.
    target_m1 = (bcol_q < BCOL_W'(WIN_COLS)) ? CNT_W'(WIN_COLS - 1) : CNT_W'(STRIDE - 1);
    band_end  = (bcol_q == BCOL_W'(IMG_W - 1));

    // Only the window-completing column waits for a held window to drain.
    col_ready = !(win_valid_q && !win_ready && (cnt_q == target_m1));
    col_fire  = col_valid && col_ready;
    win_fire  = win_valid_q && win_ready;
    completes = col_fire && (cnt_q == target_m1);

    cnt_d       = cnt_q;
    bcol_d      = bcol_q;
    win_out_d   = win_out_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (col_fire) begin
      cnt_d  = completes ? '0 : cnt_q + 1'b1;
      bcol_d = band_end ? '0 : bcol_q + 1'b1;
    end

    // A completing column wins over a simultaneous accept so the new window
    // follows with no bubble.
    if (completes) begin
      win_out_d   = win_next;
      win_valid_d = 1'b1;
      win_last_d  = band_end;
    end else if (win_fire) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bcol_q      <= '0;
      win_out_q   <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bcol_q      <= bcol_d;
      win_out_q   <= win_out_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_out   = win_out_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_window_feeder.sv
module tb_window_feeder;
  import window_feeder_pkg::*;

  localparam int BW    = 8;
  localparam int IMG_W = 98;
  localparam int CW    = WIN_ROWS * BW;
  localparam int WW    = WIN_PIX * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] col_in;
  logic          col_valid;
  logic          col_ready;
  logic [WW-1:0] win_out;
  logic          win_valid;
  logic          win_ready;
  logic          win_last;

  always #5 clk = ~clk;

  window_feeder #(.BIT_WIDTH(BW), .IMG_W(IMG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .win_out   (win_out),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
  } win_t;

  typedef struct {
    int   win;
    int   r;
    int   c;
    int   pix;
    logic last;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: the accepted column history of the current band.
  logic [CW-1:0] m_cols[$];
  win_t          m_exp[$];
  int            m_n;
  win_t          cap[$];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pat_col(input int j);
    logic [CW-1:0] c;
    for (int r = 0; r < WIN_ROWS; r++) c[(WIN_ROWS-1-r)*BW +: BW] = BW'((5 * j + r) % 256);
    return c;
  endfunction

  function automatic logic [WW-1:0] pat_win(input int s);
    logic [WW-1:0] w;
    for (int c = 0; c < WIN_COLS; c++)
      for (int r = 0; r < WIN_ROWS; r++)
        w[pix_lsb(r, c, BW) +: BW] = BW'((5 * (s + c) + r) % 256);
    return w;
  endfunction

  task automatic model_reset();
    m_cols.delete();
    m_exp.delete();
    m_n = 0;
    cap.delete();
  endtask

  // A window ends at band positions 13, 25, ..., IMG_W-1 and covers the
  // 14 most recently accepted columns.
  task automatic model_push(input logic [CW-1:0] cd);
    int   p;
    win_t e;
    m_cols.push_back(cd);
    if (m_cols.size() > WIN_COLS) void'(m_cols.pop_front());
    p = m_n % IMG_W;
    m_n++;
    if (p >= WIN_COLS - 1 && (p - (WIN_COLS - 1)) % STRIDE == 0) begin
      for (int c = 0; c < WIN_COLS; c++)
        for (int r = 0; r < WIN_ROWS; r++)
          e.win[pix_lsb(r, c, BW) +: BW] = m_cols[c][(WIN_ROWS-1-r)*BW +: BW];
      e.last = (p == IMG_W - 1);
      m_exp.push_back(e);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, then
  // advance to the next falling edge.
  task automatic cycle(input logic cv, input logic [CW-1:0] cd, input logic wr);
    win_t e;
    win_t got;
    col_valid = cv;
    col_in    = cd;
    win_ready = wr;
    #1;
    if (win_valid && win_ready) begin
      if (m_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got win_valid=1 required no pending window");
      end else begin
        e = m_exp.pop_front();
        chk("win_out", win_out, e.win);
        chk("win_last", WW'(win_last), WW'(e.last));
      end
      got.win  = win_out;
      got.last = win_last;
      cap.push_back(got);
      $display("window %0d accepted last=%0b", cap.size() - 1, win_last);
    end
    if (cv && col_ready) model_push(cd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    col_valid = 1'b0;
    win_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          tbl[9];
    logic [CW-1:0] rd;
    logic          rv;
    logic          rw;
    int            guard;

    tbl = '{
      '{0, 0,  0,   0, 1'b0},
      '{0, 4, 13,  69, 1'b0},
      '{1, 0,  0,  60, 1'b0},
      '{1, 0, 13, 125, 1'b0},
      '{1, 4, 13, 129, 1'b0},
      '{7, 0,  0, 164, 1'b1},
      '{7, 4, 13, 233, 1'b1},
      '{8, 0,  0, 234, 1'b0},
      '{8, 0, 13,  43, 1'b0}
    };

    rst_n     = 1'b0;
    col_valid = 1'b0;
    col_in    = '0;
    win_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_win_valid", WW'(win_valid), '0);
    chk("rst_win_last", WW'(win_last), '0);
    chk("rst_win_out", win_out, '0);
    chk("rst_col_ready", WW'(col_ready), WW'(1));
    rst_n = 1'b1;

    // Fill, overlap and band wrap with win_ready held high
    for (int j = 0; j < IMG_W + WIN_COLS; j++) begin
      cycle(1'b1, pat_col(j), 1'b1);
      if (j == 12) chk("valid_after_13", WW'(win_valid), '0);
      if (j == 13) chk("valid_after_14", WW'(win_valid), WW'(1));
    end
    cycle(1'b0, '0, 1'b1);
    chk("windows_band_plus", WW'(cap.size()), WW'(9));
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].win < cap.size()) begin
        chk($sformatf("tbl%0d_pix", i),
            WW'(cap[tbl[i].win].win[pix_lsb(tbl[i].r, tbl[i].c, BW) +: BW]), WW'(tbl[i].pix));
        chk($sformatf("tbl%0d_last", i), WW'(cap[tbl[i].win].last), WW'(tbl[i].last));
      end else begin
        checks++;
        errors++;
        $display("FAIL tbl%0d_missing: got %0d windows required window %0d", i, cap.size(), tbl[i].win);
      end
    end

    // Backpressure after the first window
    do_reset();
    for (int j = 0; j < WIN_COLS; j++) cycle(1'b1, pat_col(j), 1'b0);
    chk("bp_first_valid", WW'(win_valid), WW'(1));
    for (int j = WIN_COLS; j < WIN_COLS + 11; j++) cycle(1'b1, pat_col(j), 1'b0);
    chk("bp_accepted_11", WW'(m_n), WW'(25));
    chk("bp_held_win", win_out, pat_win(0));
    col_valid = 1'b1;
    col_in    = pat_col(25);
    win_ready = 1'b0;
    #1;
    chk("bp_col_ready_low", WW'(col_ready), '0);
    cycle(1'b1, pat_col(25), 1'b0);
    chk("bp_stalled_count", WW'(m_n), WW'(25));
    chk("bp_held_win2", win_out, pat_win(0));
    cycle(1'b1, pat_col(25), 1'b1);
    chk("bp_valid_stays", WW'(win_valid), WW'(1));
    chk("bp_second_win", win_out, pat_win(12));
    cycle(1'b0, '0, 1'b1);
    chk("bp_drained", WW'(win_valid), '0);
    chk("bp_windows", WW'(cap.size()), WW'(2));

    // Random idle source and sink over three bands
    do_reset();
    guard = 0;
    while (m_n < 3 * IMG_W && guard < 20000) begin
      rd = CW'({$urandom, $urandom});
      rv = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 3) != 0);
      cycle(rv, rd, rw);
      guard++;
    end
    chk("rnd_columns", WW'(m_n), WW'(3 * IMG_W));
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("rnd_windows", WW'(cap.size()), WW'(24));
    chk("rnd_pending", WW'(m_exp.size()), '0);

    // Asynchronous reset in the middle of a partial window
    do_reset();
    for (int j = 0; j < WIN_COLS + 7; j++) cycle(1'b1, pat_col(j), 1'b0);
    chk("mid_valid_before", WW'(win_valid), WW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", WW'(win_valid), '0);
    chk("mid_rst_last", WW'(win_last), '0);
    chk("mid_rst_win_out", win_out, '0);
    chk("mid_rst_col_ready", WW'(col_ready), WW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int j = 0; j < WIN_COLS - 1; j++) cycle(1'b1, pat_col(100 + j), 1'b1);
    chk("mid_no_early_win", WW'(win_valid), '0);
    cycle(1'b1, pat_col(100 + WIN_COLS - 1), 1'b1);
    chk("mid_fresh_valid", WW'(win_valid), WW'(1));
    chk("mid_fresh_win", win_out, pat_win(100));
    cycle(1'b0, '0, 1'b1);
    chk("mid_windows", WW'(cap.size()), WW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
